// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the pixel-coordinate overlay pipeline. Produces
// the horizontal/vertical pixel counters, sync pulses, visible-area flag and
// line/frame start strobes, plus copies of the syncs and visible flag delayed
// by PIPE_DELAY cycles so they line up with the registered overlay colour path.
//
// Ports:
//   clk_0        in   1   pixel clock (only clock)
//   rst          in   1   synchronous active-high reset
//   pixel_x      out  10  horizontal count, 0..H_TOTAL-1
//   pixel_y      out  10  vertical count, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync (active level SYNC_POL)
//   vsync        out  1   vertical sync (active level SYNC_POL)
//   video_on     out  1   high inside the visible area
//   frame_start  out  1   one-cycle pulse at (0, 0)
//   line_start   out  1   one-cycle pulse at pixel_x = 0
//   hsync_d      out  1   hsync delayed PIPE_DELAY cycles
//   vsync_d      out  1   vsync delayed PIPE_DELAY cycles
//   video_on_d   out  1   video_on delayed PIPE_DELAY cycles
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter bit          SYNC_POL   = 1'b0,
   parameter int unsigned PIPE_DELAY = 1
) (
   input  logic       clk_0,
   input  logic       rst,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start,
   output logic       line_start,
   output logic       hsync_d,
   output logic       vsync_d,
   output logic       video_on_d
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

   // Window bounds are 11 bits so an end bound of exactly 1024 stays exact.
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0]  next_x;
   logic [9:0]  next_y;
   logic [10:0] nx_ext;
   logic [10:0] ny_ext;
   logic        x_wrap;
   logic        hs_win;
   logic        vs_win;
   logic        vis_win;

   // Flags are decoded from the next counter values so that, once registered,
   // they describe the same pixel as the registered counters.
   always_comb begin
      x_wrap  = (pixel_x == H_MAX);
      next_x  = x_wrap ? '0 : pixel_x + 10'd1;
      next_y  = pixel_y;
      if (x_wrap) begin
         next_y = (pixel_y == V_MAX) ? '0 : pixel_y + 10'd1;
      end
      nx_ext  = {1'b0, next_x};
      ny_ext  = {1'b0, next_y};
      hs_win  = (nx_ext >= HS_START) && (nx_ext < HS_END);
      vs_win  = (ny_ext >= VS_START) && (ny_ext < VS_END);
      vis_win = (nx_ext < H_VIS_END) && (ny_ext < V_VIS_END);
   end

   // Reset parks the counters on the last blanking pixel of the frame so the
   // first post-reset edge lands on (0, 0) with a clean frame_start.
   always_ff @(posedge clk_0) begin
      if (rst) begin
         pixel_x     <= H_MAX;
         pixel_y     <= V_MAX;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         pixel_x     <= next_x;
         pixel_y     <= next_y;
         hsync       <= hs_win ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_win ? SYNC_POL : ~SYNC_POL;
         video_on    <= vis_win;
         frame_start <= (next_x == '0) && (next_y == '0);
         line_start  <= (next_x == '0);
      end
   end

   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign hsync_d    = hsync;
         assign vsync_d    = vsync;
         assign video_on_d = video_on;
      end else begin : g_dly
         logic [PIPE_DELAY-1:0] hs_pipe;
         logic [PIPE_DELAY-1:0] vs_pipe;
         logic [PIPE_DELAY-1:0] vo_pipe;

         always_ff @(posedge clk_0) begin
            if (rst) begin
               hs_pipe <= {PIPE_DELAY{~SYNC_POL}};
               vs_pipe <= {PIPE_DELAY{~SYNC_POL}};
               vo_pipe <= '0;
            end else begin
               hs_pipe[0] <= hsync;
               vs_pipe[0] <= vsync;
               vo_pipe[0] <= video_on;
               for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                  hs_pipe[i] <= hs_pipe[i-1];
                  vs_pipe[i] <= vs_pipe[i-1];
                  vo_pipe[i] <= vo_pipe[i-1];
               end
            end
         end

         assign hsync_d    = hs_pipe[PIPE_DELAY-1];
         assign vsync_d    = vs_pipe[PIPE_DELAY-1];
         assign video_on_d = vo_pipe[PIPE_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Scoreboard bench for vga_timing_gen using a shrunken raster (25 x 15) so that
// several whole frames fit in a short run. Three instances share clock/reset:
//   u_a : PIPE_DELAY = 1, SYNC_POL = 0
//   u_b : PIPE_DELAY = 0, SYNC_POL = 0
//   u_c : PIPE_DELAY = 3, SYNC_POL = 1
// A reference model pushes expected outputs at each rising edge; the checker
// pops and compares them on the following falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HV = 16, HF = 2, HS = 3, HB = 4;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;   // 25
   localparam int VT = VV + VF + VS + VB;   // 15
   localparam int FT = HT * VT;             // 375

   logic clk_0;
   logic rst;

   logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic a_hs, a_vs, a_vo, a_fs, a_ls, a_hsd, a_vsd, a_vod;
   logic b_hs, b_vs, b_vo, b_fs, b_ls, b_hsd, b_vsd, b_vod;
   logic c_hs, c_vs, c_vo, c_fs, c_ls, c_hsd, c_vsd, c_vod;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(1'b0), .PIPE_DELAY(1)
   ) u_a (
      .clk_0(clk_0), .rst(rst), .pixel_x(a_x), .pixel_y(a_y),
      .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
      .frame_start(a_fs), .line_start(a_ls),
      .hsync_d(a_hsd), .vsync_d(a_vsd), .video_on_d(a_vod)
   );

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(1'b0), .PIPE_DELAY(0)
   ) u_b (
      .clk_0(clk_0), .rst(rst), .pixel_x(b_x), .pixel_y(b_y),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
      .frame_start(b_fs), .line_start(b_ls),
      .hsync_d(b_hsd), .vsync_d(b_vsd), .video_on_d(b_vod)
   );

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(1'b1), .PIPE_DELAY(3)
   ) u_c (
      .clk_0(clk_0), .rst(rst), .pixel_x(c_x), .pixel_y(c_y),
      .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
      .frame_start(c_fs), .line_start(c_ls),
      .hsync_d(c_hsd), .vsync_d(c_vsd), .video_on_d(c_vod)
   );

   typedef struct {
      int x, y;
      bit hs, vs, vo, fs, ls, hsd, vsd, vod;
      bit b_hs, b_hsd, b_vsd, b_vod;
      bit c_hs, c_vs, c_hsd, c_vsd, c_vod;
   } exp_t;

   exp_t sb[$];

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
   endtask

   initial begin
      clk_0 = 1'b0;
      forever #5 clk_0 = ~clk_0;
   end

   // ---------------- reference model ----------------
   int mx = 0, my = 0;
   int n = 0;
   int last_rst = -100;
   bit [7:0] hh = '0, vh = '0, oh = '0;   // active-sense history by edge index

   // Source value D edges ago, forced inactive if any reset edge is that recent.
   function automatic bit dly(input bit [7:0] h, input int d);
      if (n - last_rst < d) return 1'b0;
      return h[(n - d) % 8];
   endfunction

   initial begin
      exp_t e;
      bit ha, va, vo;
      forever begin
         @(posedge clk_0);
         if (rst) begin
            mx = HT - 1; my = VT - 1;
            ha = 0; va = 0; vo = 0; e.fs = 0; e.ls = 0;
            last_rst = n;
         end else begin
            if (mx == HT - 1) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
            end else begin
               mx = mx + 1;
            end
            ha = (mx >= HV + HF) && (mx < HV + HF + HS);
            va = (my >= VV + VF) && (my < VV + VF + VS);
            vo = (mx < HV) && (my < VV);
            e.fs = (mx == 0) && (my == 0);
            e.ls = (mx == 0);
         end
         hh[n % 8] = ha; vh[n % 8] = va; oh[n % 8] = vo;
         e.x = mx; e.y = my;
         e.hs = !ha; e.vs = !va; e.vo = vo;
         e.hsd = !dly(hh, 1); e.vsd = !dly(vh, 1); e.vod = dly(oh, 1);
         e.b_hs = !ha;
         e.b_hsd = !dly(hh, 0); e.b_vsd = !dly(vh, 0); e.b_vod = dly(oh, 0);
         e.c_hs = ha; e.c_vs = va;
         e.c_hsd = dly(hh, 3); e.c_vsd = dly(vh, 3); e.c_vod = dly(oh, 3);
         sb.push_back(e);
         n++;
      end
   end

   // ---------------- checker ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_0);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("a_x", a_x, e.x);
            chk("a_y", a_y, e.y);
            chk("a_hsync", a_hs, e.hs);
            chk("a_vsync", a_vs, e.vs);
            chk("a_video_on", a_vo, e.vo);
            chk("a_frame_start", a_fs, e.fs);
            chk("a_line_start", a_ls, e.ls);
            chk("a_hsync_d", a_hsd, e.hsd);
            chk("a_vsync_d", a_vsd, e.vsd);
            chk("a_video_on_d", a_vod, e.vod);
            chk("b_hsync", b_hs, e.b_hs);
            chk("b_hsync_d", b_hsd, e.b_hsd);
            chk("b_vsync_d", b_vsd, e.b_vsd);
            chk("b_video_on_d", b_vod, e.b_vod);
            chk("c_x", c_x, e.x);
            chk("c_hsync", c_hs, e.c_hs);
            chk("c_vsync", c_vs, e.c_vs);
            chk("c_hsync_d", c_hsd, e.c_hsd);
            chk("c_vsync_d", c_vsd, e.c_vsd);
            chk("c_video_on_d", c_vod, e.c_vod);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_xy(input int tx, input int ty, input int lim);
      int k = 0;
      while (!(mx == tx && my == ty) && k < lim) begin
         @(negedge clk_0);
         k++;
      end
      if (k >= lim) chk("wait_timeout", 0, 1);
   endtask

   initial begin
      int fs_n, ls_n, vs_n, hs_n, vo_n;
      rst = 1'b1;
      repeat (3) @(posedge clk_0);
      @(negedge clk_0);
      rst = 1'b0;

      // One complete frame starting at the first post-reset (0, 0).
      fs_n = 0; ls_n = 0; vs_n = 0; hs_n = 0; vo_n = 0;
      repeat (FT) begin
         @(negedge clk_0);
         fs_n += int'(a_fs);
         ls_n += int'(a_ls);
         vs_n += int'(a_vs == 1'b0);
         hs_n += int'(a_hs == 1'b0);
         vo_n += int'(a_vo);
      end
      chk("frame_start_count", fs_n, 1);
      chk("line_start_count", ls_n, VT);
      chk("vsync_active_cycles", vs_n, VS * HT);
      chk("hsync_active_cycles", hs_n, HS * VT);
      chk("video_on_cycles", vo_n, HV * VV);
      @(negedge clk_0);
      chk("frame_start_period", a_fs, 1);

      // Mid-frame reset while hsync is active on a visible line.
      wait_xy(HV + HF + 1, 5, 2 * FT);
      rst = 1'b1;
      @(negedge clk_0);
      rst = 1'b0;

      // Reset on the cycle that would otherwise precede frame_start.
      wait_xy(0, 1, 2 * FT);
      wait_xy(HT - 1, VT - 1, 2 * FT);
      rst = 1'b1;
      @(negedge clk_0);
      rst = 1'b0;

      repeat (FT + HT) @(negedge clk_0);
      @(negedge clk_0);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
